mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 47 ++++
 rtl/load_ext.sv | 33 +++
 rtl/mem_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, load-op encodings,
// the EX-to-MEM field layout and the load-capture FSM states.
package mem_stage_pkg;

  localparam int unsigned Ex2MemWd = 328;
  localparam int unsigned Mem2WbWd = 310;
  localparam int unsigned Mem2ExWd = 70;

  // One-hot load opcodes; stores and non-memory ops carry zero.
  localparam logic [6:0] LsuOpLb  = 7'b000_0001;
  localparam logic [6:0] LsuOpLbu = 7'b000_0010;
  localparam logic [6:0] LsuOpLh  = 7'b000_0100;
  localparam logic [6:0] LsuOpLhu = 7'b000_1000;
  localparam logic [6:0] LsuOpLw  = 7'b001_0000;
  localparam logic [6:0] LsuOpLwu = 7'b010_0000;
  localparam logic [6:0] LsuOpLd  = 7'b100_0000;

  typedef enum logic {
    StLive = 1'b0,
    StHeld = 1'b1
  } cap_state_e;

  // Field order is MSB-first on the wire.
  typedef struct packed {
    logic [63:0] csr_vec;
    logic [79:0] csr_bus;
    logic [6:0]  lsu_op;
    logic [7:0]  data_ram_sel;
    logic [2:0]  sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] ex_result;
    logic [63:0] pc;
    logic [31:0] inst;
  } ex2mem_t;

  // Index of the lowest set bit; zero when no bit is set.
  function automatic logic [2:0] low_set_idx(input logic [7:0] sel);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (sel[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load alignment and extension: picks the addressed byte/half/word/double
// out of the 64-bit read data and widens it to 64 bits.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [6:0]  lsu_op_i,
  input  logic [7:0]  data_ram_sel_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] data_o
);

  logic [2:0]  offset;
  logic [63:0] shifted;

  assign offset  = low_set_idx(data_ram_sel_i);
  assign shifted = rdata_i >> {offset, 3'b000};

  // Select width and extension by the one-hot load opcode.
  always_comb begin
    data_o = '0;
    case (lsu_op_i)
      LsuOpLb:  data_o = {{56{shifted[7]}}, shifted[7:0]};
      LsuOpLbu: data_o = {56'd0, shifted[7:0]};
      LsuOpLh:  data_o = {{48{shifted[15]}}, shifted[15:0]};
      LsuOpLhu: data_o = {48'd0, shifted[15:0]};
      LsuOpLw:  data_o = {{32{shifted[31]}}, shifted[31:0]};
      LsuOpLwu: data_o = {32'd0, shifted[31:0]};
      LsuOpLd:  data_o = shifted;
      default:  data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX-to-MEM pipeline register, a capture FSM that
// freezes SRAM load data while MEM is stalled, load extension and the
// write-back / forwarding buses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned EX2MEM_WD = Ex2MemWd,
  parameter int unsigned MEM2WB_WD = Mem2WbWd,
  parameter int unsigned MEM2EX_WD = Mem2ExWd
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [5:0]           stall,
  input  logic [EX2MEM_WD-1:0] ex2mem_bus,
  input  logic [63:0]          data_sram_rdata,
  output logic [MEM2EX_WD-1:0] mem2ex_fwd,
  output logic [MEM2WB_WD-1:0] mem2wb_bus
);

  ex2mem_t     reg_q, reg_d;
  cap_state_e  state_q, state_d;
  logic [63:0] ld_buf_q, ld_buf_d;
  logic        reg_upd;
  logic [63:0] ld_src;
  logic [63:0] ld_data;
  logic [63:0] rf_wdata;

  // Only EX and MEM stall bits matter here; result-select bits 0/2 are unused.
  logic unused_bits;
  assign unused_bits = ^{stall[5], stall[2:0], reg_q.sel_rf_res[2], reg_q.sel_rf_res[0]};

  // Register content changes on flush, bubble or capture; it holds only
  // when both EX and MEM are stalled.
  assign reg_upd = flush | ~stall[3] | ~stall[4];

  // Pipeline register next state: flush, bubble, capture, else hold.
  always_comb begin
    reg_d = reg_q;
    if (flush) begin
      reg_d = '0;
    end else if (stall[3] && !stall[4]) begin
      reg_d = '0;
    end else if (!stall[3]) begin
      reg_d = ex2mem_t'(ex2mem_bus);
    end
  end

  // Capture FSM next state: grab SRAM data once when a load stalls in MEM.
  always_comb begin
    state_d  = state_q;
    ld_buf_d = ld_buf_q;
    if (reg_upd) begin
      state_d = StLive;
    end else if (state_q == StLive && reg_q.lsu_op != '0) begin
      state_d  = StHeld;
      ld_buf_d = data_sram_rdata;
    end
  end

  // State: pipeline register, FSM and load buffer, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q    <= '0;
      state_q  <= StLive;
      ld_buf_q <= '0;
    end else begin
      reg_q    <= reg_d;
      state_q  <= state_d;
      ld_buf_q <= ld_buf_d;
    end
  end

  assign ld_src = (state_q == StHeld) ? ld_buf_q : data_sram_rdata;

  load_ext u_load_ext (
    .lsu_op_i       (reg_q.lsu_op),
    .data_ram_sel_i (reg_q.data_ram_sel),
    .rdata_i        (ld_src),
    .data_o         (ld_data)
  );

  // Result select and output bus assembly.
  always_comb begin
    rf_wdata   = reg_q.sel_rf_res[1] ? ld_data : reg_q.ex_result;
    mem2ex_fwd = {reg_q.rf_we, reg_q.rf_waddr, rf_wdata};
    mem2wb_bus = {reg_q.csr_vec, reg_q.csr_bus, reg_q.rf_we, reg_q.rf_waddr, rf_wdata,
                  reg_q.pc, reg_q.inst};
  end

endmodule
